// File: rtl/reg_1b_8sz.sv
// ---------------------------------------------------------------------------
// reg_1b_8sz
//
// Eight-entry array of 1-bit elements with XOR point-update and prefix-XOR
// query. Storage is an 8-node Fenwick (binary indexed) tree. Node n holds
// the XOR of elements (n - lowbit(n)) .. (n - 1), using 0-based element
// indices. Both the update path and the query path are resolved
// combinationally from idx, so every operation completes in one cycle.
//
// Ports
//   clk    in   1  system clock, rising-edge active
//   reset  in   1  synchronous active-high reset; clears tree and out0
//   inst   in   2  00 = XOR-update, 01 = prefix query, 10/11 = no-op
//   idx    in   3  element index (update) or inclusive upper bound (query)
//   in0    in   1  update operand; ignored unless inst = 00
//   out0   out  1  registered prefix-XOR from the most recent query
// ---------------------------------------------------------------------------
module reg_1b_8sz (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] inst,
  input  logic [2:0] idx,
  input  logic       in0,
  output logic       out0
);

  localparam logic [1:0] OP_UPD = 2'b00;
  localparam logic [1:0] OP_QRY = 2'b01;

  // Lowest set bit of a 1-based tree position.
  function automatic logic [3:0] lowbit(input logic [3:0] v);
    lowbit = v & (~v + 4'd1);
  endfunction

  // Nodes touched by an update of element e: e+1, then climb by lowbit
  // until the position passes 8. A 4-bit position wraps to 0 after 8,
  // which also ends the walk. The longest path (e = 0) has four nodes.
  function automatic logic [8:1] upd_path(input logic [2:0] e);
    logic [8:1] m;
    logic [3:0] pos;
    m   = '0;
    pos = {1'b0, e} + 4'd1;
    for (int k = 0; k < 4; k++) begin
      if (pos != 4'd0 && pos <= 4'd8) begin
        m[pos] = 1'b1;
        pos    = pos + lowbit(pos);
      end
    end
    upd_path = m;
  endfunction

  // Nodes summed by a query up to element e: e+1, then descend by lowbit
  // to 0. The number of nodes equals popcount(e+1), which is at most four.
  function automatic logic [8:1] qry_path(input logic [2:0] e);
    logic [8:1] m;
    logic [3:0] pos;
    m   = '0;
    pos = {1'b0, e} + 4'd1;
    for (int k = 0; k < 4; k++) begin
      if (pos != 4'd0) begin
        m[pos] = 1'b1;
        pos    = pos - lowbit(pos);
      end
    end
    qry_path = m;
  endfunction

  logic [8:1] tree_p0;
  logic       out0_p1;

  logic       is_upd;
  logic       is_qry;
  logic [8:1] upd_mask;
  logic [8:1] qry_mask;
  logic       qry_val;

  // ---- stage 0: decode and combinational Fenwick paths ----
  always_comb begin
    is_upd   = (inst == OP_UPD);
    is_qry   = (inst == OP_QRY);
    upd_mask = upd_path(idx);
    qry_mask = qry_path(idx);
    // The query reads the tree as it stands before this edge, so an update
    // at the previous edge is already visible without a bubble.
    qry_val  = ^(tree_p0 & qry_mask);
  end

  // ---- stage 1: tree state and registered query result ----
  always_ff @(posedge clk) begin
    if (reset) begin
      tree_p0 <= '0;
      out0_p1 <= 1'b0;
    end else begin
      if (is_upd) begin
        // in0 = 0 gates the mask to zero, which leaves the tree unchanged.
        tree_p0 <= tree_p0 ^ (upd_mask & {8{in0}});
      end
      if (is_qry) begin
        out0_p1 <= qry_val;
      end
    end
  end

  assign out0 = out0_p1;

endmodule

// File: tb/tb_reg_1b_8sz.sv
module tb_reg_1b_8sz;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] inst;
  logic [2:0] idx;
  logic       in0;
  logic       out0;

  reg_1b_8sz dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst),
    .idx   (idx),
    .in0   (in0),
    .out0  (out0)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;

  logic q_exp[$];
  logic hold_exp = 1'b0;
  logic started  = 1'b0;
  logic qv       = 1'b0;
  logic [7:0] a_m = '0;

  // A query accepted at this edge means out0 carries a new result afterwards.
  always @(posedge clk) qv <= (reset === 1'b0) && (inst === 2'b01);

  // Monitor: pop one expected value per presented result; otherwise out0
  // has to hold the last expected value.
  always @(negedge clk) begin
    if (started) begin
      total++;
      if (qv) begin
        if (q_exp.size() == 0) begin
          bad++;
          $display("FAIL query_result: out0=%b with no expected value queued", out0);
        end else begin
          logic e;
          e = q_exp.pop_front();
          if (out0 !== e) begin
            bad++;
            $display("FAIL query_result: out0=%b expected=%b t=%0t", out0, e, $time);
          end
        end
      end else if (out0 !== hold_exp) begin
        bad++;
        $display("FAIL out0_hold: out0=%b expected=%b t=%0t", out0, hold_exp, $time);
      end
    end
  end

  function automatic logic model_prefix(input logic [7:0] arr, input logic [2:0] ub);
    logic r;
    r = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k <= int'(ub)) r = r ^ arr[k];
    end
    return r;
  endfunction

  // exp < 0 means use the flat-array model; otherwise a hand-computed value.
  task automatic op(input logic [1:0] i, input logic [2:0] x, input logic b,
                    input logic r, input int exp);
    logic e;
    inst  = i;
    idx   = x;
    in0   = b;
    reset = r;
    @(posedge clk);
    if (r) begin
      a_m      = '0;
      hold_exp = 1'b0;
      started  = 1'b1;
    end else begin
      case (i)
        2'b00: a_m[x] = a_m[x] ^ b;
        2'b01: begin
          e = (exp >= 0) ? exp[0] : model_prefix(a_m, x);
          q_exp.push_back(e);
          hold_exp = e;
        end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic upd(input logic [2:0] x, input logic b);
    op(2'b00, x, b, 1'b0, -1);
  endtask

  task automatic qry(input logic [2:0] x, input int exp);
    op(2'b01, x, 1'b0, 1'b0, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    inst  = 2'b10;
    idx   = 3'd0;
    in0   = 1'b0;

    // Reset with a query presented: reset wins, out0 = 0.
    op(2'b01, 3'd7, 1'b1, 1'b1, -1);
    op(2'b10, 3'd0, 1'b0, 1'b1, -1);

    // Basic update/query sequence.
    upd(3'd0, 1'b1);
    upd(3'd0, 1'b0);
    upd(3'd4, 1'b1);
    qry(3'd7, 0);
    qry(3'd3, 1);
    op(2'b01, 3'd4, 1'b1, 1'b0, 0);   // in0 ignored on a query

    // Continue: a = {4,5,6} set, a0 cleared.
    upd(3'd5, 1'b1);
    upd(3'd6, 1'b1);
    upd(3'd0, 1'b1);
    qry(3'd3, 0);
    qry(3'd7, 1);
    qry(3'd4, 1);
    qry(3'd5, 0);

    // No-ops keep out0 at its last value.
    op(2'b10, 3'd2, 1'b1, 1'b0, -1);
    op(2'b11, 3'd6, 1'b1, 1'b0, -1);

    // After reset every prefix is 0.
    op(2'b00, 3'd3, 1'b1, 1'b1, -1);
    for (int k = 0; k < 8; k++) qry(3'(k), 0);
    op(2'b11, 3'd5, 1'b1, 1'b0, -1);
    op(2'b10, 3'd1, 1'b0, 1'b0, -1);

    // Back-to-back update then query on the top element.
    upd(3'd7, 1'b1);
    qry(3'd7, 1);
    qry(3'd6, 0);
    qry(3'd7, 1);
    op(2'b11, 3'd3, 1'b1, 1'b0, -1);  // out0 holds 1

    // Reset with a simultaneous update: the update is discarded.
    op(2'b00, 3'd2, 1'b1, 1'b1, -1);
    qry(3'd7, 0);
    qry(3'd2, 0);

    // Single-element boundaries.
    upd(3'd0, 1'b1);
    qry(3'd0, 1);
    qry(3'd7, 1);
    upd(3'd3, 1'b1);
    qry(3'd2, 1);
    qry(3'd3, 0);

    // Random sequence against the flat-array model.
    for (int n = 0; n < 1200; n++) begin
      logic [1:0] ri;
      logic [2:0] rx;
      logic       rb;
      logic       rr;
      ri = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) ri = 2'b01;
      rx = 3'($urandom_range(0, 7));
      rb = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 63) == 0);
      op(ri, rx, rb, rr, -1);
    end

    op(2'b10, 3'd0, 1'b0, 1'b0, -1);
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d results still queued, expected 0", q_exp.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
